// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall control block and the
// pipeline stage registers it drives.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } hazard_state_t;

    // Counter width sized for the largest legal MEM_CYCLES (16).
    localparam int MEM_CNT_W = 4;

    // Control bundle written into a stage register when a bubble is inserted.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } stage_ctrl_t;

    localparam stage_ctrl_t NOP_CTRL = '{reg_write: 1'b0, mem_read: 1'b0,
                                         mem_write: 1'b0, branch: 1'b0};

    function automatic int mem_cnt_w(input int mem_cycles);
        return (mem_cycles <= 2) ? 1 : $clog2(mem_cycles);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter tracking the remaining frozen cycles of a
// multi-cycle memory access.
module mem_wait_counter #(
    parameter int W = hazard_pkg::MEM_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush/bubble control for hazards forwarding cannot cover: load-use,
// taken branches resolved in EX, and multi-cycle memory freezes.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MEM_CYCLES = 2,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rdest,
    input  logic [REG_ADDR_W-1:0] if_id_rsrc,
    input  logic [REG_ADDR_W-1:0] if_id_rdest,
    input  logic                  if_id_uses_rsrc,
    input  logic                  if_id_uses_rdest,
    input  logic                  ex_mem_multi,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  mem_wb_bubble,
    output logic                  busy
);

    localparam int CW = mem_cnt_w(MEM_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'((MEM_CYCLES > 2) ? MEM_CYCLES - 3 : 0);

    hazard_state_t state;
    logic          cnt_zero;
    logic          freeze;
    logic          load_use;
    logic          enter_freeze;

    assign enter_freeze = (state == RUN) && ex_mem_multi;
    assign freeze       = enter_freeze || (state == WAIT);

    assign load_use = id_ex_mem_read &&
                      ((if_id_uses_rsrc  && (id_ex_rdest == if_id_rsrc)) ||
                       (if_id_uses_rdest && (id_ex_rdest == if_id_rdest)));

    mem_wait_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (enter_freeze && (MEM_CYCLES > 2)),
        .load_val (LOAD_VAL),
        .dec      ((state == WAIT) && !cnt_zero),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_mem_multi)
                        state <= (MEM_CYCLES == 2) ? RELEASE : WAIT;
                end
                WAIT: begin
                    if (cnt_zero)
                        state <= RELEASE;
                end
                // Same instruction still in MEM, so ex_mem_multi is ignored here.
                RELEASE: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        busy          = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (freeze) begin
            // EX is held, so any branch/load-use is re-presented after the freeze.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            busy          = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: combinational hazard vectors on two instances
// (MEM_CYCLES=2 and 4) plus hand-written freeze/reset sequences.
module tb_hazard_stall_unit;

    // Output vector order: pc, if_id_w, id_ex_w, ex_mem_w, flush, id_ex_bub, mem_wb_bub, busy
    localparam logic [7:0] O_NORM = 8'b1111_0000;
    localparam logic [7:0] O_LU   = 8'b0011_0100;
    localparam logic [7:0] O_BR   = 8'b1111_1100;
    localparam logic [7:0] O_FRZ  = 8'b0000_0011;
    localparam logic [7:0] O_RST  = 8'b0000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_ex_mem_read = 1'b0;
    logic [2:0] id_ex_rdest = '0;
    logic [2:0] if_id_rsrc = '0;
    logic [2:0] if_id_rdest = '0;
    logic       if_id_uses_rsrc = 1'b0;
    logic       if_id_uses_rdest = 1'b0;
    logic       ex_mem_multi = 1'b0;
    logic       branch_taken = 1'b0;

    logic [7:0] o2, o4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_CYCLES(2), .REG_ADDR_W(3)) dut2 (
        .clk(clk), .rst(rst),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rdest(id_ex_rdest),
        .if_id_rsrc(if_id_rsrc), .if_id_rdest(if_id_rdest),
        .if_id_uses_rsrc(if_id_uses_rsrc), .if_id_uses_rdest(if_id_uses_rdest),
        .ex_mem_multi(ex_mem_multi), .branch_taken(branch_taken),
        .pc_write(o2[7]), .if_id_write(o2[6]), .id_ex_write(o2[5]), .ex_mem_write(o2[4]),
        .if_id_flush(o2[3]), .id_ex_bubble(o2[2]), .mem_wb_bubble(o2[1]), .busy(o2[0])
    );

    hazard_stall_unit #(.MEM_CYCLES(4), .REG_ADDR_W(3)) dut4 (
        .clk(clk), .rst(rst),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rdest(id_ex_rdest),
        .if_id_rsrc(if_id_rsrc), .if_id_rdest(if_id_rdest),
        .if_id_uses_rsrc(if_id_uses_rsrc), .if_id_uses_rdest(if_id_uses_rdest),
        .ex_mem_multi(ex_mem_multi), .branch_taken(branch_taken),
        .pc_write(o4[7]), .if_id_write(o4[6]), .id_ex_write(o4[5]), .ex_mem_write(o4[4]),
        .if_id_flush(o4[3]), .id_ex_bubble(o4[2]), .mem_wb_bubble(o4[1]), .busy(o4[0])
    );

    typedef struct {
        logic       mem_read;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic clear_ins();
        id_ex_mem_read = 1'b0; id_ex_rdest = '0; if_id_rsrc = '0; if_id_rdest = '0;
        if_id_uses_rsrc = 1'b0; if_id_uses_rdest = 1'b0;
        ex_mem_multi = 1'b0; branch_taken = 1'b0;
    endtask

    // Drive one cycle of stimulus at negedge, then sample before the next posedge.
    task automatic step(input logic multi, input logic br);
        @(negedge clk);
        ex_mem_multi = multi;
        branch_taken = br;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_ins();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[1]  = '{1'b1, 3'd3, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{1'b1, 3'd3, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, O_NORM};
        vecs[3]  = '{1'b1, 3'd3, 3'd1, 3'd3, 1'b0, 1'b1, 1'b0, O_LU};
        vecs[4]  = '{1'b1, 3'd3, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0, O_NORM};
        vecs[5]  = '{1'b0, 3'd3, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, O_NORM};
        vecs[6]  = '{1'b1, 3'd3, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, O_BR};
        vecs[7]  = '{1'b0, 3'd2, 3'd4, 3'd5, 1'b1, 1'b1, 1'b1, O_BR};
        vecs[8]  = '{1'b1, 3'd3, 3'd2, 3'd5, 1'b1, 1'b1, 1'b0, O_NORM};
        vecs[9]  = '{1'b1, 3'd0, 3'd0, 3'd6, 1'b1, 1'b1, 1'b0, O_LU};
        vecs[10] = '{1'b1, 3'd7, 3'd1, 3'd7, 1'b1, 1'b1, 1'b0, O_LU};

        // Reset held with a multi-cycle request pending: everything low.
        ex_mem_multi = 1'b1;
        #2;
        check("rst_hold_m2", o2, O_RST);
        check("rst_hold_m4", o4, O_RST);

        // Enter a freeze, then hit reset asynchronously mid-cycle.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("pre_freeze_m4", o4, O_FRZ);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_m2", o2, O_RST);
        check("async_rst_m4", o4, O_RST);
        @(negedge clk);
        ex_mem_multi = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_m2", o2, O_NORM);
        check("post_rst_m4", o4, O_NORM);
        step(1'b0, 1'b0);
        check("no_residual_m4", o4, O_NORM);

        // Combinational hazard table, both instances sitting in RUN.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            id_ex_mem_read   = vecs[i].mem_read;
            id_ex_rdest      = vecs[i].rd;
            if_id_rsrc       = vecs[i].rs;
            if_id_rdest      = vecs[i].rt;
            if_id_uses_rsrc  = vecs[i].use_rs;
            if_id_uses_rdest = vecs[i].use_rt;
            branch_taken     = vecs[i].br;
            #1;
            check($sformatf("vec%0d_m2", i), o2, vecs[i].exp);
            check($sformatf("vec%0d_m4", i), o4, vecs[i].exp);
        end
        clear_ins();

        // MEM_CYCLES=2: multi held two cycles -> one frozen, then RELEASE.
        pulse_reset();
        step(1'b1, 1'b0);
        check("m2_freeze", o2, O_FRZ);
        step(1'b1, 1'b0);
        check("m2_release", o2, O_NORM);
        step(1'b0, 1'b0);
        check("m2_run", o2, O_NORM);

        // MEM_CYCLES=4 with a taken branch during the freeze.
        pulse_reset();
        step(1'b1, 1'b1);
        check("m4_frz1", o4, O_FRZ);
        step(1'b0, 1'b1);
        check("m4_frz2", o4, O_FRZ);
        step(1'b0, 1'b1);
        check("m4_frz3", o4, O_FRZ);
        step(1'b1, 1'b1);
        check("m4_release_br", o4, O_BR);
        // Back-to-back multi-cycle instruction.
        step(1'b1, 1'b0);
        check("m4_b2b_frz1", o4, O_FRZ);
        step(1'b0, 1'b0);
        check("m4_b2b_frz2", o4, O_FRZ);
        step(1'b0, 1'b0);
        check("m4_b2b_frz3", o4, O_FRZ);
        step(1'b0, 1'b0);
        check("m4_b2b_release", o4, O_NORM);
        // Load-use presented in RELEASE of the next freeze stalls like RUN.
        step(1'b1, 1'b0);
        check("m4_frz_lu", o4, O_FRZ);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        id_ex_mem_read = 1'b1; id_ex_rdest = 3'd5; if_id_rsrc = 3'd5; if_id_uses_rsrc = 1'b1;
        #1;
        check("m4_release_lu", o4, O_LU);
        step(1'b0, 1'b0);
        check("m4_run_lu", o4, O_LU);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
